// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the memory-access stage.
//   WORD_W          : datapath word width
//   F3_*            : RV32I load/store funct3 encodings
//   lsu_state_t     : load/store unit FSM state encoding
//   norm_funct3     : folds unused encodings (011, 11x) onto W
//   store_strb/data : byte strobes and lane-replicated write data for stores
//   is_misaligned   : alignment check used when misalignment trapping is built in
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] norm_funct3(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_BU, F3_HU: return f3;
      default:                  return F3_W;
    endcase
  endfunction

  // Stores only look at the size bits, so BU/HU encodings behave as B/H.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] store_data(input logic [2:0] f3,
                                                   input logic [WORD_W-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword from a
// read word and sign- or zero-extends it.
//   rdata  : word returned by memory
//   addr   : low two bits of the byte address
//   funct3 : normalized load funct3 (B, H, W, BU, HU)
//   data   : extended load result
module lsu_load_align
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] lane;

  always_comb begin
    lane = rdata;
    case (funct3)
      F3_B, F3_BU: lane = rdata >> {addr, 3'b000};
      F3_H, F3_HU: lane = rdata >> {addr[1], 4'b0000};
      default:     lane = rdata;
    endcase
  end

  always_comb begin
    data = lane;
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   data = {24'b0, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   data = {16'b0, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: takes one load/store from execute, runs a registered
// request/acknowledge transaction on the data-memory port, then reports a
// load result to writeback or a store completion.
//   clk, rst (async, active-low)
//   req_*  : operation from execute, accepted while req_ready=1
//   mem_*  : data-memory port; mem_req held until mem_ack
//   wb_*   : load result; wb_valid is a one-cycle pulse, wb_rd/wb_data hold
//   st_done: one-cycle pulse when a store completes
//   fault  : one-cycle misalignment pulse, only when LSU_MISALIGN_TRAP_EN is
//            defined; otherwise tied low and low address bits are ignored
//
// state  | meaning
// IDLE   | req_ready=1, waiting for an operation
// ACCESS | mem_req high, waiting for mem_ack
// RESP   | drive wb_valid or st_done on the next edge, then back to IDLE
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              st_done,
  output logic              fault
);

  lsu_state_t        state, state_nxt;
  logic [2:0]        f3_in, f3_q;
  logic [1:0]        lane_q;
  logic              store_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_data;
  logic              accept;
  logic              misaligned;

  assign f3_in     = norm_funct3(req_funct3);
  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q;
  assign misaligned = is_misaligned(f3_in, req_addr[1:0]);
  assign fault      = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= accept && misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !misaligned) state_nxt = ACCESS;
      ACCESS:  if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata  (rdata_q),
    .addr   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q      <= F3_W;
      lane_q    <= 2'b00;
      store_q   <= 1'b0;
      rd_q      <= 5'd0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      st_done   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      st_done  <= 1'b0;

      if (accept && !misaligned) begin
        f3_q      <= f3_in;
        lane_q    <= req_addr[1:0];
        store_q   <= req_store;
        rd_q      <= req_rd;
        mem_req   <= 1'b1;
        mem_we    <= req_store;
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_wstrb <= req_store ? store_strb(f3_in, req_addr[1:0]) : 4'b0000;
        mem_wdata <= req_store ? store_data(f3_in, req_wdata) : '0;
      end

      // Read data is captured raw; extension happens from the registered copy.
      if (state == ACCESS && mem_ack) begin
        mem_req <= 1'b0;
        rdata_q <= mem_rdata;
      end

      if (state == RESP) begin
        if (store_q) begin
          st_done <= 1'b1;
        end else begin
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, st_done, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_bad = 0;
  int n_wb  = 0;
  int n_st  = 0;
  int n_flt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .fault(fault)
  );

  always @(negedge clk) begin
    if (wb_valid) n_wb++;
    if (st_done)  n_st++;
    if (fault)    n_flt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the
  // unit back in IDLE and the completion pulse already gone.
  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] rdata,
                       input int waits, input logic [31:0] exp_addr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_wb, input logic [4:0] exp_rd);
    int wb0, st0;
    wb0 = n_wb;
    st0 = n_st;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    chk({tag, ".ready_idle"}, req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      chk({tag, ".wait_req"}, mem_req, 1'b1);
      chk({tag, ".wait_addr"}, mem_addr, exp_addr);
      chk({tag, ".wait_ready"}, req_ready, 1'b0);
      // stray request while busy must be ignored
      req_valid = 1'b1;
      req_addr  = 32'hFFFF_FFF0;
      req_store = ~st;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk({tag, ".mem_req"}, mem_req, 1'b1);
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
    chk({tag, ".mem_we"}, mem_we, st);
    chk({tag, ".mem_wstrb"}, mem_wstrb, exp_strb);
    chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    chk({tag, ".req_dropped"}, mem_req, 1'b0);
    chk({tag, ".no_early_pulse"}, {wb_valid, st_done}, 2'b00);
    @(posedge clk); #1;
    chk({tag, ".wb_valid"}, wb_valid, !st);
    chk({tag, ".st_done"}, st_done, st);
    chk({tag, ".wb_data"}, wb_data, exp_wb);
    chk({tag, ".wb_rd"}, wb_rd, exp_rd);
    chk({tag, ".fault"}, fault, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".pulse_end"}, {wb_valid, st_done}, 2'b00);
    chk({tag, ".ready_back"}, req_ready, 1'b1);
    chk({tag, ".n_wb"}, n_wb - wb0, st ? 0 : 1);
    chk({tag, ".n_st"}, n_st - st0, st ? 1 : 0);
  endtask

  initial begin
    int wb_snap;
    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wstrb", mem_wstrb, 4'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.wb", {wb_valid, st_done, fault}, 3'b000);
    chk("rst.wb_rd", wb_rd, 5'd0);
    chk("rst.wb_data", wb_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //     tag      st    f3      addr          wdata         rd    rdata         w  exp_addr      strb     exp_wdata     exp_wb        exp_rd
    do_op("lhu",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        5'd5, 32'hFFF4_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_FFF4, 5'd5);
    do_op("lh",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd6, 32'hFFF4_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FFF4, 5'd6);
    do_op("lbu",   1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd7, 32'h8000_0000, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 5'd7);
    do_op("lb_r0", 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd0, 32'h8000_0000, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 5'd0);
    // stores leave wb_data/wb_rd at the last load's values
    do_op("sh",    1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd9, 32'h0,        0, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'hFFFF_FF80, 5'd0);
    do_op("lw_ws", 1'b0, 3'b010, 32'h0000_0300, 32'h0,        5'd9, 32'hDEAD_BEEF, 3, 32'h0000_0300, 4'b0000, 32'h0,        32'hDEAD_BEEF, 5'd9);
    do_op("sb",    1'b1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 5'd1, 32'h0,        1, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 5'd9);
    do_op("lb_pos",1'b0, 3'b000, 32'h0000_0001, 32'h0,        5'd3, 32'h0000_7F00, 0, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_007F, 5'd3);
    do_op("sw",    1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 5'd2, 32'h0,        0, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0000_007F, 5'd3);
    do_op("lh_lo", 1'b0, 3'b001, 32'h0000_0000, 32'h0,        5'd4, 32'h0001_8000, 0, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_8000, 5'd4);
    do_op("f3_ill",1'b0, 3'b011, 32'h0000_0020, 32'h0,        5'd8, 32'hCAFE_F00D, 0, 32'h0000_0020, 4'b0000, 32'h0,        32'hCAFE_F00D, 5'd8);

    // reset in the middle of ACCESS
    wb_snap    = n_wb;
    req_valid  = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr   = 32'h0000_0400; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid.mem_req_up", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.mem_req_drop", mem_req, 1'b0);
    chk("mid.ready", req_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1 mem_ack = 1'b0;
    chk("mid.ack_ignored", mem_req, 1'b0);
    chk("mid.ready_after", req_ready, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("mid.no_wb", n_wb - wb_snap, 0);
    chk("mid.wb_data_cleared", wb_data, 32'h0);
    do_op("lhu2",  1'b0, 3'b101, 32'h0000_0102, 32'h0,        5'd5, 32'hFFF4_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_FFF4, 5'd5);

`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr  = 32'h0000_0101; req_rd = 5'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mis.mem_req", mem_req, 1'b0);
    chk("mis.fault", fault, 1'b1);
    chk("mis.ready", req_ready, 1'b1);
    @(posedge clk); #1;
    chk("mis.fault_end", fault, 1'b0);
    chk("mis.mem_req2", mem_req, 1'b0);
    chk("mis.n_fault", n_flt, 1);
    chk("mis.no_wb", wb_valid, 1'b0);
`else
    // without trapping a misaligned word simply uses the whole word
    do_op("lw_mis",1'b0, 3'b010, 32'h0000_0101, 32'h0,        5'd12,32'h1122_3344, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h1122_3344, 5'd12);
    chk("fault_tied", n_flt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
